// File: rtl/bus_direction_arbiter_if.sv
// Bus direction arbiter handshake bundle.
// Requests, grants, inbound handshake, outbound drive, beat indices.
interface bus_direction_arbiter_if #(
  parameter int IDX_W = 3
);
  logic             rd_req;
  logic             rd_grant;
  logic             rd_done;
  logic             wr_req;
  logic             wr_grant;
  logic             wr_done;
  logic             bus_valid;
  logic             bus_ready;
  logic             driving_busses;
  logic             output_valid;
  logic [IDX_W-1:0] rd_beat_idx;
  logic [IDX_W-1:0] wr_beat_idx;
  logic             busy;

  modport master (
    input  rd_req, wr_req, bus_valid,
    output rd_grant, rd_done, wr_grant, wr_done,
    output bus_ready, driving_busses, output_valid,
    output rd_beat_idx, wr_beat_idx, busy
  );

  modport slave (
    output rd_req, wr_req, bus_valid,
    input  rd_grant, rd_done, wr_grant, wr_done,
    input  bus_ready, driving_busses, output_valid,
    input  rd_beat_idx, wr_beat_idx, busy
  );
endinterface

// File: rtl/bus_direction_arbiter.sv
// Shares one bidirectional bus between read and write bursts.
// Round-robin burst grants with turnaround dead cycles.
module bus_direction_arbiter #(
  parameter int RD_BURST          = 6,
  parameter int WR_BURST          = 6,
  parameter int TURNAROUND_CYCLES = 1,
  parameter int IDX_W             = 3
) (
  input logic clk,
  input logic arst_n_in,
  bus_direction_arbiter_if.master bus
);

  localparam int TW =
    (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE, TURN, READ, WRITE
  } state_t;

  typedef enum logic {
    DIR_RD, DIR_WR
  } dir_t;

  state_t           state_q, state_d;
  dir_t             last_dir_q, last_dir_d;
  dir_t             last_grant_q, last_grant_d;
  dir_t             pending_q, pending_d;
  dir_t             sel;
  logic [TW-1:0]    turn_cnt_q, turn_cnt_d;
  logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;

  // State and counter registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      state_q      <= IDLE;
      last_dir_q   <= DIR_RD;
      last_grant_q <= DIR_WR;
      pending_q    <= DIR_RD;
      turn_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_dir_q   <= last_dir_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      turn_cnt_q   <= turn_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  // Arbitration, turnaround, beat counting and bus outputs
  always_comb begin
    state_d            = state_q;
    last_dir_d         = last_dir_q;
    last_grant_d       = last_grant_q;
    pending_d          = pending_q;
    turn_cnt_d         = turn_cnt_q;
    rd_cnt_d           = rd_cnt_q;
    wr_cnt_d           = wr_cnt_q;
    sel                = DIR_RD;
    bus.rd_grant       = 1'b0;
    bus.rd_done        = 1'b0;
    bus.wr_grant       = 1'b0;
    bus.wr_done        = 1'b0;
    bus.bus_ready      = 1'b0;
    bus.driving_busses = 1'b0;
    bus.output_valid   = 1'b0;
    bus.rd_beat_idx    = '0;
    bus.wr_beat_idx    = '0;
    bus.busy           = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (bus.rd_req && bus.wr_req)
          sel = (last_grant_q == DIR_RD) ? DIR_WR : DIR_RD;
        else
          sel = bus.wr_req ? DIR_WR : DIR_RD;
        if (arst_n_in && (bus.rd_req || bus.wr_req)) begin
          bus.rd_grant = (sel == DIR_RD);
          bus.wr_grant = (sel == DIR_WR);
          last_grant_d = sel;
          if (sel == last_dir_q) begin
            state_d = (sel == DIR_WR) ? WRITE : READ;
          end else begin
            state_d    = TURN;
            pending_d  = sel;
            turn_cnt_d = '0;
          end
        end
      end
      TURN: begin
        turn_cnt_d = turn_cnt_q + TW'(1);
        if (turn_cnt_q == TW'(TURNAROUND_CYCLES - 1)) begin
          turn_cnt_d = '0;
          last_dir_d = pending_q;
          state_d    = (pending_q == DIR_WR) ? WRITE : READ;
        end
      end
      READ: begin
        bus.bus_ready   = 1'b1;
        bus.rd_beat_idx = rd_cnt_q;
        if (bus.bus_valid) begin
          rd_cnt_d = rd_cnt_q + IDX_W'(1);
          if (rd_cnt_q == IDX_W'(RD_BURST - 1)) begin
            bus.rd_done = arst_n_in;
            rd_cnt_d    = '0;
            state_d     = IDLE;
          end
        end
      end
      WRITE: begin
        bus.driving_busses = 1'b1;
        bus.output_valid   = 1'b1;
        bus.wr_beat_idx    = wr_cnt_q;
        wr_cnt_d           = wr_cnt_q + IDX_W'(1);
        if (wr_cnt_q == IDX_W'(WR_BURST - 1)) begin
          bus.wr_done = arst_n_in;
          wr_cnt_d    = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_direction_arbiter.sv
// Bench for bus_direction_arbiter: directed scenarios plus
// random traffic against a burst-schedule reference model.
module tb_bus_direction_arbiter;

  localparam int RD = 6;
  localparam int WR = 6;
  localparam int TA = 1;

  typedef struct packed {
    logic       rg;
    logic       rdn;
    logic       wg;
    logic       wdn;
    logic       rdy;
    logic       drv;
    logic       ov;
    logic [2:0] ridx;
    logic [2:0] widx;
    logic       busy;
  } obs_t;

  logic clk = 1'b0;
  logic arst_n;
  logic rd_req, wr_req, bus_valid;
  logic auto_drop;

  int n_checks = 0;
  int n_err = 0;

  obs_t rec  [64];
  obs_t rec3 [64];
  logic p_rdy, p_drv;
  logic drop_rd, drop_wr;

  int m_left, m_dead, m_dir, m_beat;
  int m_last_dir, m_last_grant;

  always #5 clk = ~clk;

  bus_direction_arbiter_if #(.IDX_W(3)) bi ();
  bus_direction_arbiter_if #(.IDX_W(3)) bi3 ();

  assign bi.rd_req     = rd_req;
  assign bi.wr_req     = wr_req;
  assign bi.bus_valid  = bus_valid;
  assign bi3.rd_req    = rd_req;
  assign bi3.wr_req    = wr_req;
  assign bi3.bus_valid = bus_valid;

  bus_direction_arbiter #(
    .RD_BURST(RD), .WR_BURST(WR),
    .TURNAROUND_CYCLES(TA), .IDX_W(3)
  ) dut (
    .clk(clk), .arst_n_in(arst_n), .bus(bi)
  );

  bus_direction_arbiter #(
    .RD_BURST(RD), .WR_BURST(WR),
    .TURNAROUND_CYCLES(3), .IDX_W(3)
  ) dut3 (
    .clk(clk), .arst_n_in(arst_n), .bus(bi3)
  );

  task automatic chk(input string tag, input int k,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d got=%0h expected=%0h",
             tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    m_left       = 0;
    m_dead       = 0;
    m_dir        = 0;
    m_beat       = 0;
    m_last_dir   = 0;
    m_last_grant = 1;
  endtask

  // Reference: a granted burst is a count of dead cycles
  // followed by a count of beats still owed.
  task automatic model(output obs_t e);
    int sel;
    e = '0;
    if (m_left == 0) begin
      if (arst_n && (rd_req || wr_req)) begin
        if (rd_req && wr_req) sel = 1 - m_last_grant;
        else sel = wr_req ? 1 : 0;
        e.rg = (sel == 0);
        e.wg = (sel == 1);
        m_dead = (sel != m_last_dir) ? TA : 0;
        m_last_grant = sel;
        m_last_dir = sel;
        m_dir = sel;
        m_beat = 0;
        m_left = sel ? WR : RD;
      end
    end else begin
      e.busy = 1'b1;
      if (m_dead > 0) begin
        m_dead--;
      end else if (m_dir == 0) begin
        e.rdy  = 1'b1;
        e.ridx = 3'(m_beat);
        if (bus_valid) begin
          m_beat++;
          m_left--;
          e.rdn = (m_left == 0) && arst_n;
        end
      end else begin
        e.drv  = 1'b1;
        e.ov   = 1'b1;
        e.widx = 3'(m_beat);
        m_beat++;
        m_left--;
        e.wdn = (m_left == 0) && arst_n;
      end
    end
    if (!arst_n) model_reset();
  endtask

  task automatic cyc(input int k);
    obs_t o, o3, e;
    #2;
    o  = {bi.rd_grant, bi.rd_done, bi.wr_grant,
          bi.wr_done, bi.bus_ready, bi.driving_busses,
          bi.output_valid, bi.rd_beat_idx,
          bi.wr_beat_idx, bi.busy};
    o3 = {bi3.rd_grant, bi3.rd_done, bi3.wr_grant,
          bi3.wr_done, bi3.bus_ready, bi3.driving_busses,
          bi3.output_valid, bi3.rd_beat_idx,
          bi3.wr_beat_idx, bi3.busy};
    model(e);
    chk("outputs_vs_model", k, 32'(o), 32'(e));
    chk("ready_and_drive", k, 32'(o.rdy & o.drv), 0);
    chk("drive_after_ready", k, 32'(o.drv & p_rdy), 0);
    chk("ready_after_drive", k, 32'(o.rdy & p_drv), 0);
    if (k >= 0 && k < 64) begin
      rec[k]  = o;
      rec3[k] = o3;
    end
    p_rdy   = o.rdy;
    p_drv   = o.drv;
    drop_rd = auto_drop && o.rg;
    drop_wr = auto_drop && o.wg;
    @(posedge clk);
    #1;
    if (drop_rd) rd_req = 1'b0;
    if (drop_wr) wr_req = 1'b0;
  endtask

  task automatic do_reset();
    arst_n    = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    bus_valid = 1'b0;
    auto_drop = 1'b1;
    cyc(-1);
    cyc(-1);
    arst_n = 1'b1;
  endtask

  initial begin
    int hs, dn;
    arst_n    = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    bus_valid = 1'b0;
    auto_drop = 1'b1;
    p_rdy     = 1'b0;
    p_drv     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state
    cyc(0);
    chk("reset_outputs", 0, 32'(rec[0]), 0);
    arst_n = 1'b1;

    // single read burst, bus_valid always high
    do_reset();
    rd_req    = 1'b1;
    bus_valid = 1'b1;
    for (int k = 0; k < 9; k++) cyc(k);
    chk("rd_grant_c0", 0, 32'(rec[0].rg), 1);
    for (int k = 1; k <= 6; k++) begin
      chk("rd_ready", k, 32'(rec[k].rdy), 1);
      chk("rd_idx", k, 32'(rec[k].ridx), 32'(k - 1));
    end
    chk("rd_done_c5", 5, 32'(rec[5].rdn), 0);
    chk("rd_done_c6", 6, 32'(rec[6].rdn), 1);
    chk("rd_idle_c7", 7, 32'(rec[7].busy), 0);

    // single write burst from reset: turnaround first
    do_reset();
    wr_req = 1'b1;
    for (int k = 0; k < 10; k++) cyc(k);
    chk("wr_grant_c0", 0, 32'(rec[0].wg), 1);
    chk("wr_turn_c1", 1,
        32'({rec[1].busy, rec[1].drv, rec[1].rdy}), 32'b100);
    for (int k = 2; k <= 7; k++) begin
      chk("wr_drive", k, 32'({rec[k].drv, rec[k].ov}), 3);
      chk("wr_idx", k, 32'(rec[k].widx), 32'(k - 2));
    end
    chk("wr_done_c7", 7, 32'(rec[7].wdn), 1);
    chk("wr_idle_c8", 8, 32'(rec[8].busy), 0);

    // continuous contention: strict alternation
    do_reset();
    auto_drop = 1'b0;
    rd_req    = 1'b1;
    wr_req    = 1'b1;
    bus_valid = 1'b1;
    for (int k = 0; k < 25; k++) cyc(k);
    chk("alt_r0", 0, 32'({rec[0].rg, rec[0].wg}), 2);
    chk("alt_w7", 7, 32'({rec[7].rg, rec[7].wg}), 1);
    chk("alt_r15", 15, 32'({rec[15].rg, rec[15].wg}), 2);
    chk("alt_w23", 23, 32'({rec[23].rg, rec[23].wg}), 1);
    chk("alt_dead8", 8,
        32'({rec[8].busy, rec[8].drv, rec[8].rdy}), 32'b100);
    chk("alt_dead16", 16,
        32'({rec[16].busy, rec[16].drv, rec[16].rdy}), 32'b100);
    chk("alt_wr9", 9, 32'(rec[9].drv), 1);
    chk("alt_rd17", 17, 32'(rec[17].rdy), 1);
    auto_drop = 1'b1;

    // read burst with two 3-cycle stalls
    do_reset();
    rd_req = 1'b1;
    hs = 0;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      bus_valid = !((k >= 3 && k <= 5) || (k >= 8 && k <= 10));
      cyc(k);
      if (rec[k].rdy && bus_valid) hs++;
      if (rec[k].rdn) dn++;
    end
    chk("stall_hold_b2", 4, 32'(rec[4].ridx), 2);
    chk("stall_hold_b4", 9, 32'(rec[9].ridx), 4);
    chk("stall_done_c12", 12, 32'(rec[12].rdn), 1);
    chk("stall_handshakes", 14, 32'(hs), 6);
    chk("stall_done_count", 14, 32'(dn), 1);
    chk("stall_idle_c13", 13, 32'(rec[13].busy), 0);

    // reset during write beat 3, then a fresh write
    do_reset();
    wr_req    = 1'b1;
    bus_valid = 1'b0;
    dn = 0;
    for (int k = 0; k < 11; k++) begin
      arst_n = (k != 5);
      if (k == 7) wr_req = 1'b1;
      cyc(k);
      if (k <= 6 && rec[k].wdn) dn++;
    end
    chk("abort_beat3", 5,
        32'({rec[5].drv, rec[5].widx}), 32'b1011);
    chk("abort_outputs", 6, 32'(rec[6]), 0);
    chk("abort_no_done", 6, 32'(dn), 0);
    chk("abort_regrant", 7, 32'(rec[7].wg), 1);
    chk("abort_turn", 8,
        32'({rec[8].busy, rec[8].drv}), 32'b10);
    chk("abort_drive", 9, 32'(rec[9].drv), 1);

    // three-cycle turnaround on the second instance
    do_reset();
    rd_req    = 1'b1;
    bus_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 7) wr_req = 1'b1;
      cyc(k);
    end
    chk("ta3_rd_done", 6, 32'(rec3[6].rdn), 1);
    chk("ta3_wr_grant", 7, 32'(rec3[7].wg), 1);
    for (int k = 8; k <= 10; k++)
      chk("ta3_dead", k,
          32'({rec3[k].busy, rec3[k].drv, rec3[k].rdy, rec3[k].ov}),
          32'b1000);
    chk("ta3_first_ov", 11,
        32'({rec3[11].ov, rec3[11].widx}), 32'b1000);

    // random traffic with occasional resets
    do_reset();
    for (int k = 0; k < 800; k++) begin
      bus_valid = ($urandom_range(3) != 0);
      arst_n    = ($urandom_range(149) != 0);
      if (!rd_req) rd_req = ($urandom_range(2) == 0);
      if (!wr_req) wr_req = ($urandom_range(2) == 0);
      cyc(k + 100);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/bus_direction_arbiter.md
Name: bus_direction_arbiter

Overview:
- Shares the single bidirectional testbench bus between two requesters: the feature-fetch sequencer (inbound bursts) and the output-writeback sequencer (outbound bursts).
- Grants whole bursts, round-robin when both sides request.
- Inserts bus-turnaround idle cycles whenever the bus direction changes.
- Generates the bus handshake, drive-enable and per-beat indices consumed by the feature/output mux selects.

Parameters:
- RD_BURST, 6, inbound words per read burst (>=1).
- WR_BURST, 6, outbound words per write burst (>=1).
- TURNAROUND_CYCLES, 1, dead cycles on a direction change (>=1).
- IDX_W, 3, width of beat indices; must satisfy 2**IDX_W >= max(RD_BURST, WR_BURST).

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  reset, synchronous, active-low (sampled on rising clk edge only).
- rd_req  in  1  fetch sequencer requests one read burst; held until rd_grant.
- rd_grant  out  1  one-cycle pulse: read burst accepted.
- rd_done  out  1  one-cycle pulse on the final read beat handshake.
- wr_req  in  1  writeback sequencer requests one write burst; held until wr_grant.
- wr_grant  out  1  one-cycle pulse: write burst accepted.
- wr_done  out  1  one-cycle pulse on the final write beat.
- bus_valid  in  1  inbound word present.
- bus_ready  out  1  arbiter accepts inbound word.
- driving_busses  out  1  DUT drives the bus.
- output_valid  out  1  outbound word valid this cycle.
- rd_beat_idx  out  IDX_W  index of the current read beat.
- wr_beat_idx  out  IDX_W  index of the current write beat.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, TURN, READ, WRITE.
- Registers:
  - last_dir: reset READ (bus undriven at reset).
  - last_grant: reset WRITE, so read wins the first tie.
  - pending_dir.
  - turn_cnt, rd_cnt, wr_cnt: all reset 0.
- Reset: every output is 0 and the state is IDLE. A reset mid-burst aborts the burst silently, with no done pulse, and all counters clear.
- IDLE arbitration (combinational, same cycle):
  - Only one request: select it.
  - Both requests: select the direction opposite last_grant.
  - Assert the selected grant for that cycle only and update last_grant.
  - If selected dir == last_dir, the next state is READ/WRITE. Otherwise the next state is TURN with pending_dir = selected and turn_cnt = 0.
  - No request: stay in IDLE.
- TURN:
  - All bus outputs are 0.
  - turn_cnt increments each cycle.
  - When turn_cnt == TURNAROUND_CYCLES-1, go to pending_dir and set last_dir = pending_dir.
- READ:
  - bus_ready = 1 and rd_beat_idx = rd_cnt.
  - rd_cnt advances only on bus_valid && bus_ready; a stall holds the index.
  - On a handshake with rd_cnt == RD_BURST-1: rd_done = 1 that cycle, rd_cnt -> 0, next state IDLE.
- WRITE:
  - driving_busses = 1, output_valid = 1, wr_beat_idx = wr_cnt. There is no backpressure.
  - wr_cnt advances every cycle.
  - When wr_cnt == WR_BURST-1: wr_done = 1 that cycle, wr_cnt -> 0, next state IDLE.
- Timing:
  - Every burst is followed by at least one IDLE cycle.
  - Back-to-back same-direction bursts have a 1-cycle gap.
  - A direction change adds TURNAROUND_CYCLES further cycles.
- Exclusivity invariants:
  - driving_busses and bus_ready are never both 1.
  - driving_busses never rises in the cycle after bus_ready was 1, and vice versa.
- Requests raised outside IDLE are held by the requester and serviced at the next IDLE. Fairness is strict alternation under continuous contention, so neither side waits more than one opposing burst.
- rd_done/wr_done are combinational from state and counter (rd_done also depends on bus_valid). Grants depend on req and state only. There are no combinational paths from req to bus signals.

Test Plan:
- Reset, then rd_req = 1 at cycle 0 with bus_valid always 1 -> rd_grant at cycle 0; bus_ready high in cycles 1-6; rd_beat_idx 0..5; rd_done at cycle 6; IDLE at cycle 7; no TURN.
- Reset, then wr_req only -> wr_grant at cycle 0; TURN at cycle 1; driving_busses/output_valid high in cycles 2-7; wr_beat_idx 0..5; wr_done at cycle 7.
- rd_req and wr_req both held high continuously -> grants alternate R, W, R, W. Each read→write and write→read change shows exactly 1 cycle with bus_ready = driving_busses = 0 after the IDLE cycle, so the two are never adjacent-high.
- Read burst with bus_valid low at beats 2 and 4 for 3 cycles each -> rd_beat_idx holds during stalls; burst takes 12 cycles; exactly 6 handshakes; one rd_done.
- arst_n_in low during write beat 3 -> at the next edge all outputs 0, no wr_done, state IDLE. A subsequent wr_req gets a grant and then TURN, because last_dir resets to READ.
- TURNAROUND_CYCLES = 3, read then write -> exactly 3 dead TURN cycles between IDLE and the first output_valid.
